// File: rtl/seq_pattern_detector_pkg.sv
// rtl/seq_pattern_detector_pkg.sv - shared types and helpers for the sequence detector
package seq_pattern_detector_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int clamp_len(input int len, input int depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/seq_history.sv
// rtl/seq_history.sv - symbol history shift register, fill counter and pattern compare
// r_hist[0] holds the most recent accepted symbol; match_raw is combinational from sym_in.
module seq_history
  import seq_pattern_detector_pkg::*;
#(
  parameter  int SYM_W = 2,
  parameter  int DEPTH = 4,
  localparam int LEN_W = len_width(DEPTH),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic                   clear,
  input  logic [SYM_W-1:0]       sym_in,
  input  logic [DEPTH*SYM_W-1:0] pattern,
  input  logic [LEN_W-1:0]       len,
  output logic                   match_raw,
  output logic [LEN_W-1:0]       fill
);

  logic [SYM_W-1:0] r_hist [DEPTH];
  logic [LEN_W-1:0] r_fill;
  logic [SYM_W-1:0] w_pat  [DEPTH];
  logic             w_hist_eq;
  logic             w_last_eq;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_pat[k] = pattern[k*SYM_W +: SYM_W];
    end
  end

  // History slot j must equal pattern element len-2-j for the len-1 newest slots.
  always_comb begin
    w_hist_eq = 1'b1;
    for (int j = 0; j < DEPTH - 1; j++) begin
      if ((j + 1 < int'(len)) && (r_hist[j] != w_pat[IDX_W'(int'(len) - 2 - j)])) begin
        w_hist_eq = 1'b0;
      end
    end
  end

  assign w_last_eq = (len != '0) && (sym_in == w_pat[IDX_W'(int'(len) - 1)]);
  assign match_raw = w_last_eq && w_hist_eq && (int'(r_fill) + 1 >= int'(len));
  assign fill      = r_fill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_hist[j] <= '0;
      end
      r_fill <= '0;
    end else begin
      if (shift_en) begin
        r_hist[0] <= sym_in;
        for (int j = 1; j < DEPTH; j++) begin
          r_hist[j] <= r_hist[j-1];
        end
      end
      if (clear) begin
        r_fill <= '0;
      end else if (shift_en && (r_fill != LEN_W'(DEPTH))) begin
        r_fill <= r_fill + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - runtime-configurable symbol sequence detector with hold and match count
module seq_pattern_detector
  import seq_pattern_detector_pkg::*;
#(
  parameter  int SYM_W = 2,
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 8,
  localparam int LEN_W = len_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_en,
  input  logic [SYM_W-1:0]       sym_in,
  input  logic                   cfg_load,
  input  logic [DEPTH*SYM_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   cfg_overlap,
  input  logic                   cfg_hold_en,
  input  logic [SYM_W-1:0]       cfg_hold_sym,
  output logic                   match_pulse,
  output logic                   match_level,
  output logic [CNT_W-1:0]       match_count,
  output logic [LEN_W-1:0]       fill
);

  logic [DEPTH*SYM_W-1:0] r_pat;
  logic [LEN_W-1:0]       r_len;
  logic                   r_overlap;
  logic                   r_hold_en;
  logic [SYM_W-1:0]       r_hold_sym;
  state_e                 r_state;
  state_e                 w_next;
  logic                   r_pulse;
  logic [CNT_W-1:0]       r_count;
  logic                   w_accept;
  logic                   w_match_raw;
  logic                   w_match;
  logic                   w_hist_clr;

  // cfg_load wins over a coincident sample, which is dropped entirely.
  assign w_accept   = sample_en & ~cfg_load;
  assign w_match    = w_accept & w_match_raw;
  assign w_hist_clr = cfg_load | (w_match & ~r_overlap);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat      <= '0;
      r_len      <= '0;
      r_overlap  <= 1'b0;
      r_hold_en  <= 1'b0;
      r_hold_sym <= '0;
    end else if (cfg_load) begin
      r_pat      <= cfg_pattern;
      r_len      <= LEN_W'(clamp_len(int'(cfg_len), DEPTH));
      r_overlap  <= cfg_overlap;
      r_hold_en  <= cfg_hold_en;
      r_hold_sym <= cfg_hold_sym;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (cfg_load) begin
      w_next = HUNT;
    end else if (w_accept) begin
      if (w_match_raw) begin
        w_next = HOLD;
      end else if ((r_state == HOLD) && r_hold_en && (sym_in == r_hold_sym)) begin
        w_next = HOLD;
      end else begin
        w_next = HUNT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pulse <= 1'b0;
      r_count <= '0;
    end else begin
      r_pulse <= w_match;
      if (cfg_load) begin
        r_count <= '0;
      end else if (w_match && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  seq_history #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH)
  ) u_history (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (w_accept),
    .clear     (w_hist_clr),
    .sym_in    (sym_in),
    .pattern   (r_pat),
    .len       (r_len),
    .match_raw (w_match_raw),
    .fill      (fill)
  );

  assign match_pulse = r_pulse;
  assign match_level = (r_state == HOLD);
  assign match_count = r_count;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - self-checking bench for seq_pattern_detector
module tb_seq_pattern_detector;

  localparam int SYM_W   = 2;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 3;
  localparam int CNT_MAX = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   sample_en;
  logic [SYM_W-1:0]       sym_in;
  logic                   cfg_load;
  logic [DEPTH*SYM_W-1:0] cfg_pattern;
  logic [LEN_W-1:0]       cfg_len;
  logic                   cfg_overlap;
  logic                   cfg_hold_en;
  logic [SYM_W-1:0]       cfg_hold_sym;
  logic                   match_pulse;
  logic                   match_level;
  logic [CNT_W-1:0]       match_count;
  logic [LEN_W-1:0]       fill;

  seq_pattern_detector #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_en    (sample_en),
    .sym_in       (sym_in),
    .cfg_load     (cfg_load),
    .cfg_pattern  (cfg_pattern),
    .cfg_len      (cfg_len),
    .cfg_overlap  (cfg_overlap),
    .cfg_hold_en  (cfg_hold_en),
    .cfg_hold_sym (cfg_hold_sym),
    .match_pulse  (match_pulse),
    .match_level  (match_level),
    .match_count  (match_count),
    .fill         (fill)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int pulses  = 0;

  // Reference model: valid history as a queue, oldest first.
  logic [SYM_W-1:0] m_q [$];
  logic [SYM_W-1:0] mc_pat [DEPTH];
  int               mc_len;
  bit               mc_ov, mc_hen;
  logic [SYM_W-1:0] mc_hsym;
  bit               m_pulse, m_level;
  int               m_count;

  typedef struct {
    bit         en;
    logic [1:0] sym;
    int         exp;
  } vec_t;
  vec_t tbl [7];

  function automatic int pk(input int p, input int l, input int c, input int f);
    return p * 1000 + l * 100 + c * 10 + f;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int k = 0; k < DEPTH; k++) mc_pat[k] = '0;
    mc_len  = 0;
    mc_ov   = 0;
    mc_hen  = 0;
    mc_hsym = '0;
    m_pulse = 0;
    m_level = 0;
    m_count = 0;
  endtask

  task automatic model_edge(input bit load, input bit en, input logic [1:0] sym);
    int  L;
    bit  hit;
    if (load) begin
      for (int k = 0; k < DEPTH; k++) mc_pat[k] = cfg_pattern[k*SYM_W +: SYM_W];
      mc_len  = int'(cfg_len);
      mc_ov   = cfg_overlap;
      mc_hen  = cfg_hold_en;
      mc_hsym = cfg_hold_sym;
      m_q.delete();
      m_count = 0;
      m_pulse = 0;
      m_level = 0;
    end else if (en) begin
      L   = (mc_len > DEPTH) ? DEPTH : mc_len;
      hit = 0;
      if (L >= 1 && m_q.size() >= L - 1) begin
        hit = (sym == mc_pat[L-1]);
        for (int k = 0; k < L - 1; k++)
          if (m_q[m_q.size() - (L - 1) + k] != mc_pat[k]) hit = 0;
      end
      m_pulse = hit;
      if (hit) begin
        if (m_count < CNT_MAX) m_count++;
        m_level = 1;
      end else if (!(m_level && mc_hen && sym == mc_hsym)) begin
        m_level = 0;
      end
      m_q.push_back(sym);
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
      if (hit && !mc_ov) m_q.delete();
    end else begin
      m_pulse = 0;
    end
  endtask

  function automatic int dut_pk();
    return pk(int'(match_pulse), int'(match_level), int'(match_count), int'(fill));
  endfunction

  task automatic step(input bit load, input bit en, input logic [1:0] sym);
    cfg_load  = load;
    sample_en = en;
    sym_in    = sym;
    @(posedge clk);
    model_edge(load, en, sym);
    #1;
    cfg_load  = 1'b0;
    sample_en = 1'b0;
    if (match_pulse) pulses++;
    check("model", dut_pk(), pk(int'(m_pulse), int'(m_level), m_count, m_q.size()));
  endtask

  task automatic do_load(input logic [7:0] pat, input int len, input bit ov,
                         input bit hen, input logic [1:0] hs);
    cfg_pattern  = pat;
    cfg_len      = LEN_W'(len);
    cfg_overlap  = ov;
    cfg_hold_en  = hen;
    cfg_hold_sym = hs;
    step(1'b1, 1'b0, 2'b00);
    pulses = 0;
  endtask

  initial begin
    logic [1:0] s;
    reset        = 1'b1;
    sample_en    = 1'b0;
    sym_in       = '0;
    cfg_load     = 1'b0;
    cfg_pattern  = '0;
    cfg_len      = '0;
    cfg_overlap  = 1'b0;
    cfg_hold_en  = 1'b0;
    cfg_hold_sym = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_pk(), 0);
    reset = 1'b0;

    // Unconfigured detector: zero pattern, length 0 never matches.
    step(1'b0, 1'b1, 2'b00);
    step(1'b0, 1'b1, 2'b00);
    check("unconfigured_no_pulse", pulses, 0);

    // Hold scenario, table driven.
    tbl[0] = '{1'b1, 2'b10, 1};
    tbl[1] = '{1'b1, 2'b11, 2};
    tbl[2] = '{1'b1, 2'b10, 1110};
    tbl[3] = '{1'b1, 2'b01, 111};
    tbl[4] = '{1'b0, 2'b00, 111};
    tbl[5] = '{1'b1, 2'b01, 112};
    tbl[6] = '{1'b1, 2'b00, 13};
    do_load(8'b00101110, 3, 1'b0, 1'b1, 2'b01);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, tbl[i].en, tbl[i].sym);
      check($sformatf("hold_tbl_%0d", i), dut_pk(), tbl[i].exp);
    end
    check("hold_pulses", pulses, 1);

    // Overlap on / off.
    do_load(8'b00101110, 3, 1'b1, 1'b0, 2'b00);
    foreach (tbl[i]) if (i < 5) step(1'b0, 1'b1, (i % 2 == 0) ? 2'b10 : 2'b11);
    check("overlap1_pulses", pulses, 2);
    check("overlap1_count", int'(match_count), 2);
    do_load(8'b00101110, 3, 1'b0, 1'b0, 2'b00);
    foreach (tbl[i]) if (i < 5) step(1'b0, 1'b1, (i % 2 == 0) ? 2'b10 : 2'b11);
    check("overlap0_pulses", pulses, 1);

    // hold_en=0: level lasts one sample interval, idle cycles do not move it.
    do_load(8'b00000101, 2, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 2'b01);
    check("nohold_lvl_s1", int'(match_level), 0);
    step(1'b0, 1'b1, 2'b01);
    check("nohold_lvl_s2", int'(match_level), 1);
    step(1'b0, 1'b0, 2'b11);
    check("nohold_lvl_idle", int'(match_level), 1);
    step(1'b0, 1'b1, 2'b11);
    check("nohold_lvl_s3", int'(match_level), 0);

    // Length 0 disables; length 7 clamps to 4.
    do_load(8'b00000000, 0, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 2'($urandom_range(0, 1)));
    check("len0_pulses", pulses, 0);
    check("len0_count", int'(match_count), 0);
    do_load(8'b00111001, 7, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b10);
    step(1'b0, 1'b1, 2'b11);
    check("len7_no_early", pulses, 0);
    step(1'b0, 1'b1, 2'b00);
    check("len7_pulse_4th", int'(match_pulse), 1);

    // Saturation with L=1 and samples every cycle.
    do_load(8'b00000011, 1, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 2'b11);
      check($sformatf("sat_pulse_%0d", i), int'(match_pulse), 1);
    end
    check("sat_pulses", pulses, 5);
    check("sat_count", int'(match_count), 3);

    // cfg_load coincident with a completing sample while in HOLD.
    do_load(8'b00101110, 3, 1'b1, 1'b1, 2'b11);
    step(1'b0, 1'b1, 2'b10);
    step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b1, 2'b10);
    step(1'b0, 1'b1, 2'b11);
    check("load_pre_hold", dut_pk(), pk(0, 1, 1, 4));
    step(1'b1, 1'b1, 2'b10);
    check("load_drops_sample", dut_pk(), 0);
    step(1'b0, 1'b1, 2'b10);
    check("load_then_sample", dut_pk(), pk(0, 0, 0, 1));

    // Asynchronous reset in HOLD.
    do_load(8'b00101110, 3, 1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b10);
    step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b1, 2'b10);
    check("pre_reset_hold", int'(match_level), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", dut_pk(), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b1, 2'b10);

    // Randomized traffic, including unlatched cfg churn and stray loads.
    for (int r = 0; r < 6; r++) begin
      do_load(8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 3),
              1'($urandom), 1'($urandom), 2'($urandom));
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          cfg_pattern  = 8'($urandom);
          cfg_len      = 3'($urandom_range(0, 7));
          cfg_overlap  = 1'($urandom);
          cfg_hold_en  = 1'($urandom);
          cfg_hold_sym = 2'($urandom);
        end
        s = $urandom_range(0, 1) ? mc_pat[$urandom_range(0, DEPTH - 1)] : 2'($urandom_range(0, 3));
        step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), s);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
